// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and its ALU.
// Holds the opcodes, FSM encoding and datapath width so each has one definition.
package alu_arbiter_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_MUL = 4'd2;
  localparam logic [3:0] ALU_OP_DIV = 4'd3;
  localparam logic [3:0] ALU_OP_MOD = 4'd4;
  localparam logic [3:0] ALU_OP_NOT = 4'd5;
  localparam logic [3:0] ALU_OP_AND = 4'd6;
  localparam logic [3:0] ALU_OP_OR  = 4'd7;
  localparam logic [3:0] ALU_OP_XOR = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic              id;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU shared by both requesters; covers opcodes ADD through OR.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_OP_ADD: y_o = a_i + b_i;
      ALU_OP_SUB: y_o = a_i - b_i;
      ALU_OP_MUL: y_o = a_i * b_i;
      // Zero divisor yields 0 so the output never goes unknown.
      ALU_OP_DIV: y_o = (b_i == '0) ? '0 : a_i / b_i;
      ALU_OP_MOD: y_o = (b_i == '0) ? '0 : a_i % b_i;
      ALU_OP_NOT: y_o = ~a_i;
      ALU_OP_AND: y_o = a_i & b_i;
      ALU_OP_OR:  y_o = a_i | b_i;
      default:    y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: arbitrates, registers operands,
// executes one operation at a time and returns a tagged response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit         RR_ENABLE = 1'b1,
  parameter logic [3:0] OP_MAX    = 4'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        state_o
);

  // Handshakes: a request transfers in the cycle reqN_valid && reqN_ready; a
  // response transfers in the cycle rsp_valid && rsp_ready. reqN_ready is a
  // combinational grant pulse and only ever rises while IDLE.

  logic [1:0]        state_q, state_d;
  alu_req_t          req_q, req_d;
  logic              rr_last_q, rr_last_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              any_valid;
  logic              grant_id;
  logic              grant;
  logic [DATA_W-1:0] alu_y;
  logic              exec_err;
  logic [DATA_W-1:0] exec_data;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = RR_ENABLE ? ~rr_last_q : 1'b0;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign grant      = (state_q == ST_IDLE) && any_valid;
  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;

  alu u_alu (
    .op_i (req_q.op),
    .a_i  (req_q.a),
    .b_i  (req_q.b),
    .y_o  (alu_y)
  );

  // Errors override the raw ALU output; XOR is computed locally.
  always_comb begin
    exec_err = ((req_q.op == ALU_OP_DIV || req_q.op == ALU_OP_MOD) && req_q.b == '0)
               || (req_q.op > OP_MAX);
    if (exec_err) begin
      exec_data = '0;
    end else if (req_q.op == ALU_OP_XOR) begin
      exec_data = req_q.a ^ req_q.b;
    end else begin
      exec_data = alu_y;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rr_last_d  = rr_last_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_d.id  = grant_id;
          req_d.op  = grant_id ? req1_op : req0_op;
          req_d.a   = grant_id ? req1_a  : req0_a;
          req_d.b   = grant_id ? req1_b  : req0_b;
          rr_last_d = grant_id;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d   = req_q.id;
        rsp_data_d = exec_data;
        rsp_err_d  = exec_err;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rr_last_q  <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rr_last_q  <= rr_last_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_o   = state_q;

endmodule
